// File: rtl/risc_pkg.sv
// Shared types and widths for the instruction sequencer and its decoder.
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 8;
  localparam int RADDR_W = 4;
  localparam int PC_W    = 3;

  localparam logic [3:0] OP_LI   = 4'b0001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction from the latched instruction and opcode.
module instr_decode
  import risc_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  input  logic [3:0]         i_opr,
  output logic               o_is_li,
  output logic               o_is_halt,
  output logic [RADDR_W-1:0] o_rd,
  output logic [RADDR_W-1:0] o_ra,
  output logic [RADDR_W-1:0] o_rb,
  output logic [DATA_W-1:0]  o_imm
);

  assign o_is_li   = (i_opr == OP_LI);
  assign o_is_halt = (i_opr == OP_HALT);
  // LI places its destination where ALU ops carry source A
  assign o_rd      = o_is_li ? i_ir[11:8] : i_ir[15:12];
  assign o_ra      = i_ir[11:8];
  assign o_rb      = i_ir[7:4];
  assign o_imm     = i_ir[7:0];

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer over an external
// program store, register file and ALU.
//   state  | meaning
//   IDLE   | waiting for start, all outputs quiet
//   FETCH  | latch instruction word and opcode at pc
//   DECODE | present register read addresses, branch on opcode
//   EXEC   | latch ALU result
//   WB     | one-cycle register file write, advance or wrap pc
//   DONE   | one-cycle done pulse, pc cleared
module instr_sequencer
  import risc_pkg::*;
#(
  parameter int PROG_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [PC_W-1:0]    instr_addr,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic [3:0]         op_data,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_op,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
);

  state_t               r_state, w_next;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic [3:0]           r_opr;
  logic [DATA_W-1:0]    r_res;

  logic                 w_is_li, w_is_halt, w_rd_phase, w_last;
  logic [RADDR_W-1:0]   w_rd, w_ra, w_rb;
  logic [DATA_W-1:0]    w_imm;

  instr_decode u_decode (
    .i_ir      (r_ir),
    .i_opr     (r_opr),
    .o_is_li   (w_is_li),
    .o_is_halt (w_is_halt),
    .o_rd      (w_rd),
    .o_ra      (w_ra),
    .o_rb      (w_rb),
    .o_imm     (w_imm)
  );

  assign w_last = (r_pc == PC_W'(PROG_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_halt)    w_next = S_DONE;
        else if (w_is_li) w_next = S_WB;
        else              w_next = S_EXEC;
      end
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_opr <= '0;
      r_res <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_pc <= '0;
        S_FETCH: begin
          r_ir  <= instr_data;
          r_opr <= op_data;
        end
        S_EXEC:  r_res <= alu_result;
        S_WB:    r_pc  <= w_last ? '0 : r_pc + 3'd1;
        S_DONE:  r_pc  <= '0;
        default: ;
      endcase
    end
  end

  assign w_rd_phase = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WB);

  always_comb begin
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    if (w_rd_phase) begin
      rf_raddr1 = w_ra;
      rf_raddr2 = w_rb;
      alu_a     = rf_rdata1;
      alu_b     = rf_rdata2;
      alu_op    = r_opr;
    end
    if (r_state == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = w_rd;
      rf_wdata = w_is_li ? w_imm : r_res;
    end
  end

  assign instr_addr = r_pc;
  assign pc         = r_pc;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule
